// File: rtl/if_bus_fetch_pkg.sv
// ============================================================================
//  Module      : if_bus_fetch_pkg
//  Description : Shared types and constants for the IF-stage fetch bus master.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_bus_fetch_pkg;

   localparam int WORD_ADDR_W = 30;
   localparam int WORD_DATA_W = 32;

   typedef logic [WORD_ADDR_W-1:0] WordAddrBus;
   typedef logic [WORD_DATA_W-1:0] WordDataBus;

   typedef enum logic [2:0] {
      FETCH_IDLE   = 3'd0,
      FETCH_REQ    = 3'd1,
      FETCH_ACCESS = 3'd2,
      FETCH_DRAIN  = 3'd3,
      FETCH_DONE   = 3'd4
   } fetch_state_e;

   localparam WordDataBus ISA_NOP = 32'h0000_0000;

   localparam logic READ    = 1'b1;
   localparam logic WRITE   = 1'b0;
   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

endpackage

`default_nettype wire

// File: rtl/if_bus_fetch.sv
// ============================================================================
//  Module      : if_bus_fetch
//  Description : Instruction-fetch bus master: arbitrates, runs one read,
//                returns the word or a NOP on flush/timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_bus_fetch
   import if_bus_fetch_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_en,
   input  WordAddrBus req_pc,
   input  logic       flush,
   output logic       busy,
   output WordDataBus insn,
   output logic       fetch_err,
   output logic       bus_req,
   input  logic       bus_grant,
   output logic       bus_as,
   output logic       bus_rw,
   output WordAddrBus bus_addr,
   input  WordDataBus bus_rd_data,
   input  logic       bus_rdy
);

   localparam logic [TO_W-1:0] C_TIMEOUT = TO_W'(TIMEOUT);

   fetch_state_e    state_q, state_d;
   WordAddrBus      addr_q, addr_d;
   WordDataBus      insn_q, insn_d;
   logic            err_q, err_d;
   logic [TO_W-1:0] cnt_q, cnt_d;

   logic            on_bus;
   logic            expired;

   assign on_bus  = (state_q == FETCH_ACCESS) || (state_q == FETCH_DRAIN);
   assign expired = (cnt_q == C_TIMEOUT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH_IDLE;
         addr_q  <= '0;
         insn_q  <= ISA_NOP;
         err_q   <= DISABLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         insn_q  <= insn_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      insn_d  = insn_q;
      err_d   = DISABLE;
      cnt_d   = cnt_q;

      // Counter saturates on the compare so it can never wrap past TIMEOUT.
      if (on_bus && !expired) begin
         cnt_d = cnt_q + TO_W'(1);
      end

      unique case (state_q)
         FETCH_IDLE: begin
            if (req_en && !flush) begin
               addr_d  = req_pc;
               state_d = FETCH_REQ;
            end
         end
         FETCH_REQ: begin
            if (flush) begin
               state_d = FETCH_IDLE;
            end else if (bus_grant) begin
               cnt_d   = '0;
               state_d = FETCH_ACCESS;
            end
         end
         FETCH_ACCESS: begin
            if (bus_rdy) begin
               insn_d  = flush ? ISA_NOP : bus_rd_data;
               state_d = FETCH_DONE;
            end else if (expired) begin
               insn_d  = ISA_NOP;
               err_d   = ENABLE;
               state_d = FETCH_DONE;
            end else if (flush) begin
               state_d = FETCH_DRAIN;
            end
         end
         FETCH_DRAIN: begin
            // The slave has seen the strobe; wait it out, then discard.
            if (bus_rdy) begin
               insn_d  = ISA_NOP;
               state_d = FETCH_DONE;
            end else if (expired) begin
               insn_d  = ISA_NOP;
               err_d   = ENABLE;
               state_d = FETCH_DONE;
            end
         end
         FETCH_DONE: begin
            state_d = FETCH_IDLE;
         end
         default: begin
            state_d = FETCH_IDLE;
         end
      endcase
   end

   assign busy      = (state_q == FETCH_REQ) || on_bus ||
                      ((state_q == FETCH_IDLE) && req_en && !flush);
   assign bus_req   = (state_q == FETCH_REQ) || on_bus;
   assign bus_as    = on_bus;
   assign bus_rw    = READ;
   assign bus_addr  = addr_q;
   assign insn      = insn_q;
   assign fetch_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_if_bus_fetch.sv
// ============================================================================
//  Module      : tb_if_bus_fetch
//  Description : Self-checking bench for if_bus_fetch against a flag-based
//                transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_bus_fetch;
   import if_bus_fetch_pkg::*;

   localparam int unsigned TIMEOUT = 4;
   localparam int unsigned TO_W    = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_en;
   logic [29:0] req_pc;
   logic        flush;
   logic        busy;
   logic [31:0] insn;
   logic        fetch_err;
   logic        bus_req;
   logic        bus_grant;
   logic        bus_as;
   logic        bus_rw;
   logic [29:0] bus_addr;
   logic [31:0] bus_rd_data;
   logic        bus_rdy;

   if_bus_fetch #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_en      (req_en),
      .req_pc      (req_pc),
      .flush       (flush),
      .busy        (busy),
      .insn        (insn),
      .fetch_err   (fetch_err),
      .bus_req     (bus_req),
      .bus_grant   (bus_grant),
      .bus_as      (bus_as),
      .bus_rw      (bus_rw),
      .bus_addr    (bus_addr),
      .bus_rd_data (bus_rd_data),
      .bus_rdy     (bus_rdy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: a request is either waiting for grant, on the bus, or
   // in its one closing cycle; on_bus age counts cycles spent with AS high.
   logic        m_wait_grant, m_on_bus, m_discard, m_closing, m_err;
   int          m_age;
   logic [31:0] m_insn;
   logic [29:0] m_addr;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_step();
      logic err_n;
      logic age_hit;
      err_n = 1'b0;
      if (reset) begin
         m_wait_grant = 1'b0; m_on_bus = 1'b0; m_discard = 1'b0;
         m_closing = 1'b0; m_age = 0; m_insn = ISA_NOP; m_addr = '0;
      end else if (m_closing) begin
         m_closing = 1'b0;
      end else if (m_wait_grant) begin
         if (flush) begin
            m_wait_grant = 1'b0;
         end else if (bus_grant) begin
            m_wait_grant = 1'b0; m_on_bus = 1'b1; m_discard = 1'b0; m_age = 0;
         end
      end else if (m_on_bus) begin
         age_hit = (m_age >= int'(TIMEOUT));
         m_age++;
         if (bus_rdy) begin
            m_insn   = (m_discard || flush) ? ISA_NOP : bus_rd_data;
            m_on_bus = 1'b0; m_closing = 1'b1;
         end else if (age_hit) begin
            m_insn   = ISA_NOP; err_n = 1'b1;
            m_on_bus = 1'b0; m_closing = 1'b1;
         end else if (flush) begin
            m_discard = 1'b1;
         end
      end else if (req_en && !flush) begin
         m_wait_grant = 1'b1;
         m_addr       = req_pc;
      end
      m_err = reset ? 1'b0 : err_n;
   endtask

   task automatic check_outputs();
      logic idle;
      idle = !(m_wait_grant || m_on_bus || m_closing);
      check_eq("busy",      {31'b0, busy},      {31'b0, m_wait_grant | m_on_bus | (idle & req_en & ~flush)});
      check_eq("bus_req",   {31'b0, bus_req},   {31'b0, m_wait_grant | m_on_bus});
      check_eq("bus_as",    {31'b0, bus_as},    {31'b0, m_on_bus});
      check_eq("bus_rw",    {31'b0, bus_rw},    32'd1);
      check_eq("bus_addr",  {2'b0, bus_addr},   {2'b0, m_addr});
      check_eq("insn",      insn,               m_insn);
      check_eq("fetch_err", {31'b0, fetch_err}, {31'b0, m_err});
   endtask

   // One clock of stimulus: drive, check before the edge, then advance model.
   task automatic drive(input logic rst, input logic rq, input logic [29:0] pc,
                        input logic fl, input logic gr, input logic rd,
                        input logic [31:0] data);
      reset = rst; req_en = rq; req_pc = pc; flush = fl;
      bus_grant = gr; bus_rdy = rd; bus_rd_data = data;
      #3;
      check_outputs();
      @(posedge clk);
      model_step();
      cyc++;
      #1;
   endtask

   initial begin
      reset = 1'b1; req_en = 1'b0; req_pc = '0; flush = 1'b0;
      bus_grant = 1'b0; bus_rdy = 1'b0; bus_rd_data = '0;
      @(posedge clk);
      model_step();
      #1;

      // Reset state with no request pending.
      drive(0, 0, 30'h0, 0, 0, 0, 32'h0);

      // Basic minimum-latency fetch.
      drive(0, 1, 30'h100, 0, 1, 1, 32'h1234_5678);
      drive(0, 1, 30'h100, 0, 1, 1, 32'h1234_5678);
      drive(0, 1, 30'h100, 0, 1, 1, 32'h1234_5678);
      drive(0, 0, 30'h100, 0, 0, 0, 32'h0);
      check_eq("basic_insn", insn, 32'h1234_5678);

      // Wait states: grant after 3 cycles, rdy after 4 ACCESS cycles.
      drive(0, 1, 30'h2A5, 0, 0, 0, 32'h0);
      repeat (3) drive(0, 1, 30'h2A5, 0, 0, 0, 32'h0);
      drive(0, 1, 30'h2A5, 0, 1, 0, 32'h0);
      repeat (4) drive(0, 1, 30'h2A5, 0, 0, 0, 32'h0);
      drive(0, 1, 30'h2A5, 0, 0, 1, 32'hCAFE_F00D);
      drive(0, 0, 30'h0, 0, 0, 0, 32'h0);
      check_eq("wait_insn", insn, 32'hCAFE_F00D);

      // Flush while waiting for grant.
      drive(0, 1, 30'h333, 0, 0, 0, 32'h0);
      drive(0, 1, 30'h333, 1, 0, 0, 32'h0);
      drive(0, 0, 30'h333, 0, 0, 0, 32'h0);
      check_eq("flush_req_insn", insn, 32'hCAFE_F00D);

      // Flush during ACCESS, rdy two cycles later.
      drive(0, 1, 30'h444, 0, 1, 0, 32'h0);
      drive(0, 1, 30'h444, 0, 1, 0, 32'h0);
      drive(0, 1, 30'h444, 1, 0, 0, 32'h0);
      drive(0, 0, 30'h444, 0, 0, 0, 32'h0);
      drive(0, 0, 30'h444, 0, 0, 1, 32'hDEAD_BEEF);
      drive(0, 0, 30'h0, 0, 0, 0, 32'h0);
      check_eq("drain_insn", insn, ISA_NOP);

      // Timeout: rdy never arrives.
      drive(0, 1, 30'h555, 0, 1, 0, 32'h0);
      drive(0, 1, 30'h555, 0, 1, 0, 32'h0);
      repeat (5) drive(0, 1, 30'h555, 0, 0, 0, 32'h0);
      drive(0, 0, 30'h0, 0, 0, 0, 32'h0);
      drive(0, 0, 30'h0, 0, 0, 0, 32'h0);

      // Reset mid-ACCESS, then a clean fetch.
      drive(0, 1, 30'h666, 0, 1, 0, 32'h0);
      drive(0, 1, 30'h666, 0, 1, 0, 32'h0);
      drive(0, 1, 30'h666, 0, 0, 0, 32'h0);
      drive(1, 1, 30'h666, 0, 0, 0, 32'h0);
      drive(0, 1, 30'h777, 0, 1, 1, 32'h0BAD_C0DE);
      drive(0, 1, 30'h777, 0, 1, 1, 32'h0BAD_C0DE);
      drive(0, 1, 30'h777, 0, 1, 1, 32'h0BAD_C0DE);
      drive(0, 0, 30'h0, 0, 0, 0, 32'h0);
      check_eq("post_reset_insn", insn, 32'h0BAD_C0DE);

      // Randomized traffic.
      for (int i = 0; i < 4000; i++) begin
         drive($urandom_range(0, 199) == 0,
               $urandom_range(0, 99) < 75,
               30'($urandom),
               $urandom_range(0, 99) < 8,
               $urandom_range(0, 99) < 50,
               $urandom_range(0, 99) < 30,
               $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
